instr_sequencer: RTL and testbench

// - Fetch/decode/execute controller that drives the 5-bit program counter.
// - Fetches 8-bit instructions over a REQ/ACK handshake and decodes the opcode.
// - Issues single-cycle PC step/jump commands and hands EXEC ops to the ALU datapath.
// - Keeps a hardware return stack for CALL/RET. Sits between PC, instruction memory and datapath.

---
 rtl/instr_sequencer_pkg.sv | 14 +
 rtl/instr_sequencer_if.sv | 26 ++
 rtl/instr_sequencer_stack.sv | 29 ++
 rtl/instr_sequencer.sv | 100 ++++++++++
 tb/tb_instr_sequencer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: opcode, state and instruction types shared by the sequencer slice.
package instr_sequencer_pkg;
  localparam int OPC_W = 3;
  typedef enum logic [OPC_W-1:0] {
    OP_NOP, OP_EXEC, OP_JMP, OP_JZ, OP_CALL, OP_RET, OP_HALT, OP_RSVD
  } opcode_e;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_WAIT, S_HALTED
  } state_e;
  typedef struct packed {
    opcode_e    opcode;
    logic [4:0] operand;
  } instr_t;
endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: fetch, PC, datapath and status signals around the sequencer.
interface instr_sequencer_if #(parameter int AW = 5) ();
  logic          START;
  logic [AW-1:0] PC_IN;
  logic          IMEM_REQ;
  logic          IMEM_ACK;
  logic [7:0]    IMEM_DATA;
  logic          ZERO_FLAG;
  logic          EXEC_EN;
  logic [AW-1:0] EXEC_ARG;
  logic          EXEC_DONE;
  logic          PC_STEP;
  logic          PC_JMP;
  logic [AW-1:0] PC_JMP_ADDR;
  logic          BUSY;
  logic          HALTED;
  logic          ERR;
  modport master (
    input  START, PC_IN, IMEM_ACK, IMEM_DATA, ZERO_FLAG, EXEC_DONE,
    output IMEM_REQ, EXEC_EN, EXEC_ARG, PC_STEP, PC_JMP, PC_JMP_ADDR, BUSY, HALTED, ERR
  );
  modport slave (
    output START, PC_IN, IMEM_ACK, IMEM_DATA, ZERO_FLAG, EXEC_DONE,
    input  IMEM_REQ, EXEC_EN, EXEC_ARG, PC_STEP, PC_JMP, PC_JMP_ADDR, BUSY, HALTED, ERR
  );
endinterface

// File: rtl/instr_sequencer_stack.sv
// seq_return_stack: LIFO of return addresses; push and pop are never requested together.
module seq_return_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_top,
  output logic         o_full,
  output logic         o_empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [PW:0]  r_sp;
  logic [PW-1:0] w_top_idx;
  always_ff @(posedge CLK or posedge RST)
    if (RST) r_sp <= '0;
    else if (i_push) r_sp <= r_sp + 1'b1;
    else if (i_pop) r_sp <= r_sp - 1'b1;
  always_ff @(posedge CLK)
    if (i_push) r_mem[r_sp[PW-1:0]] <= i_data;
  assign w_top_idx = r_sp[PW-1:0] - PW'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_full    = r_sp == (PW+1)'(DEPTH);
  assign o_empty   = r_sp == '0;
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute FSM driving PC step/jump, ALU strobes and a return stack.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int AW          = 5
) (
  input logic              CLK,
  input logic              RST,
  instr_sequencer_if.master bus
);
  state_e        r_state, w_next;
  instr_t        r_ir;
  logic          w_step, w_jmp, w_exec, w_err, w_push, w_pop, w_full, w_empty;
  logic [AW-1:0] w_addr, w_top, w_arg;
  assign w_arg = AW'(r_ir.operand);
  seq_return_stack #(.DEPTH(STACK_DEPTH), .W(AW)) u_stack (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (bus.PC_IN + AW'(1)),
    .o_top   (w_top),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && bus.IMEM_ACK) r_ir <= instr_t'(bus.IMEM_DATA);
    end
  always_comb begin
    w_next = r_state;
    w_step = 1'b0;
    w_jmp  = 1'b0;
    w_addr = '0;
    w_exec = 1'b0;
    w_err  = 1'b0;
    w_push = 1'b0;
    w_pop  = 1'b0;
    case (r_state)
      S_FETCH: w_next = bus.IMEM_ACK ? S_DECODE : S_FETCH;
      S_EXEC_WAIT: begin
        w_step = bus.EXEC_DONE;
        w_next = bus.EXEC_DONE ? S_FETCH : S_EXEC_WAIT;
      end
      S_DECODE: begin
        w_next = S_FETCH;
        case (r_ir.opcode)
          OP_NOP:  w_step = 1'b1;
          OP_EXEC: begin
            w_exec = 1'b1;
            w_next = S_EXEC_WAIT;
          end
          OP_JMP: begin
            w_jmp  = 1'b1;
            w_addr = w_arg;
          end
          OP_JZ: begin
            w_jmp  = bus.ZERO_FLAG;
            w_step = !bus.ZERO_FLAG;
            w_addr = bus.ZERO_FLAG ? w_arg : '0;
          end
          OP_CALL: begin
            w_err  = w_full;
            w_push = !w_full;
            w_jmp  = !w_full;
            w_addr = w_full ? '0 : w_arg;
            w_next = w_full ? S_HALTED : S_FETCH;
          end
          OP_RET: begin
            w_err  = w_empty;
            w_pop  = !w_empty;
            w_jmp  = !w_empty;
            w_addr = w_empty ? '0 : w_top;
            w_next = w_empty ? S_HALTED : S_FETCH;
          end
          OP_HALT: w_next = S_HALTED;
          OP_RSVD: begin
            w_err  = 1'b1;
            w_step = 1'b1;
          end
        endcase
      end
      default: w_next = bus.START ? S_FETCH : r_state;
    endcase
  end
  assign bus.IMEM_REQ    = r_state == S_FETCH;
  assign bus.BUSY        = !(r_state == S_IDLE || r_state == S_HALTED);
  assign bus.HALTED      = r_state == S_HALTED;
  assign bus.EXEC_EN     = w_exec;
  assign bus.EXEC_ARG    = w_exec ? w_arg : '0;
  assign bus.PC_STEP     = w_step;
  assign bus.PC_JMP      = w_jmp;
  assign bus.PC_JMP_ADDR = w_addr;
  assign bus.ERR         = w_err;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scoreboard bench predicting each decode cycle from a reference model.
module tb_instr_sequencer;
  logic CLK = 1'b0;
  logic RST;
  instr_sequencer_if #(.AW(5)) bus ();
  instr_sequencer #(.STACK_DEPTH(4), .AW(5)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  typedef struct packed {
    logic [13:0] v;
    logic        halt;
  } exp_t;
  exp_t       sb[$];
  logic [4:0] stk[$];
  int         checks = 0;
  int         passed = 0;
  logic [13:0] obs;
  assign obs = {bus.PC_STEP, bus.PC_JMP, bus.PC_JMP_ADDR, bus.ERR, bus.EXEC_EN, bus.EXEC_ARG};
  function automatic exp_t predict(input logic [7:0] d);
    logic st = 0, jp = 0, er = 0, ex = 0, h = 0;
    logic [4:0] ad = '0, ar = '0, a = d[4:0];
    case (d[7:5])
      3'd0: st = 1;
      3'd1: begin ex = 1; ar = a; end
      3'd2: begin jp = 1; ad = a; end
      3'd3: if (bus.ZERO_FLAG) begin jp = 1; ad = a; end else st = 1;
      3'd4: if (stk.size() == 4) begin er = 1; h = 1; end
            else begin stk.push_back(bus.PC_IN + 5'd1); jp = 1; ad = a; end
      3'd5: if (stk.size() == 0) begin er = 1; h = 1; end
            else begin ad = stk.pop_back(); jp = 1; end
      3'd6: h = 1;
      default: begin er = 1; st = 1; end
    endcase
    return '{v: {st, jp, ad, er, ex, ar}, halt: h};
  endfunction
  task automatic fetch(input logic [7:0] d, input int dly, output int req);
    req = 0;
    for (int i = 0; i <= dly; i++) begin
      if (bus.IMEM_REQ === 1'b1) req++;
      bus.IMEM_DATA = d;
      bus.IMEM_ACK  = (i == dly);
      @(negedge CLK);
    end
    bus.IMEM_ACK  = 1'b0;
    bus.IMEM_DATA = '0;
  endtask
  task automatic run_instr(input logic [7:0] d, input string nm);
    exp_t e;
    int r;
    sb.push_back(predict(d));
    fetch(d, 1, r);
    e = sb.pop_front();
    checks++;
    if (obs !== e.v) $display("FAIL %s decode: got %h want %h", nm, obs, e.v);
    else passed++;
    @(negedge CLK);
    checks++;
    if (bus.HALTED !== e.halt) $display("FAIL %s halted: got %b want %b", nm, bus.HALTED, e.halt);
    else passed++;
  endtask
  task automatic do_reset();
    RST = 1'b1;
    bus.START = 0; bus.IMEM_ACK = 0; bus.IMEM_DATA = '0;
    bus.ZERO_FLAG = 0; bus.EXEC_DONE = 0; bus.PC_IN = '0;
    stk.delete();
    sb.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask
  task automatic start();
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
  endtask
  task automatic test_reset();
    exp_t e;
    int r;
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({bus.IMEM_REQ, bus.EXEC_EN, bus.EXEC_ARG, bus.PC_STEP, bus.PC_JMP, bus.PC_JMP_ADDR,
         bus.BUSY, bus.HALTED, bus.ERR} !== 17'h0)
      $display("FAIL reset outputs: got nonzero, want all 0");
    else passed++;
    do_reset();
    start();
    sb.push_back(predict(8'h00));
    fetch(8'h00, 2, r);
    checks++;
    if (r !== 3) $display("FAIL nop req_cycles: got %0d want 3", r);
    else passed++;
    e = sb.pop_front();
    checks++;
    if (obs !== e.v) $display("FAIL nop decode: got %h want %h", obs, e.v);
    else passed++;
    checks++;
    if ({bus.IMEM_REQ, bus.BUSY} !== 2'b01) $display("FAIL nop decode req/busy: got %b want 01", {bus.IMEM_REQ, bus.BUSY});
    else passed++;
    @(negedge CLK);
  endtask
  task automatic test_jz();
    bus.PC_IN = 5'd3;
    bus.ZERO_FLAG = 1'b1;
    run_instr(8'h6A, "jz_taken");
    bus.ZERO_FLAG = 1'b0;
    run_instr(8'h6A, "jz_not_taken");
    run_instr(8'h47, "jmp");
  endtask
  task automatic test_call_wrap();
    do_reset();
    start();
    bus.PC_IN = 5'd31;
    run_instr(8'h85, "call_wrap");
    run_instr(8'hA0, "ret_wrap");
    run_instr(8'hA0, "ret_after_empty");
  endtask
  task automatic test_stack_overflow();
    do_reset();
    start();
    bus.PC_IN = 5'd2;
    for (int i = 0; i < 5; i++) begin
      bus.PC_IN = 5'(2 + i);
      run_instr(8'h81 + 8'(i), $sformatf("call_%0d", i));
    end
    do_reset();
    start();
    run_instr(8'hA0, "ret_empty");
  endtask
  task automatic test_exec();
    exp_t e;
    int r;
    do_reset();
    start();
    sb.push_back(predict(8'h33));
    fetch(8'h33, 1, r);
    e = sb.pop_front();
    checks++;
    if (obs !== e.v) $display("FAIL exec decode: got %h want %h", obs, e.v);
    else passed++;
    bus.EXEC_DONE = 1'b1;
    @(negedge CLK);
    for (int w = 1; w <= 4; w++) begin
      bus.EXEC_DONE = (w == 4);
      #1;
      checks++;
      if ({bus.PC_STEP, bus.BUSY, bus.EXEC_EN} !== {(w == 4), 1'b1, 1'b0})
        $display("FAIL exec_wait_%0d step/busy/en: got %b want %b", w,
                 {bus.PC_STEP, bus.BUSY, bus.EXEC_EN}, {(w == 4), 1'b1, 1'b0});
      else passed++;
      @(negedge CLK);
    end
    bus.EXEC_DONE = 1'b0;
    checks++;
    if (bus.IMEM_REQ !== 1'b1) $display("FAIL exec refetch req: got %b want 1", bus.IMEM_REQ);
    else passed++;
  endtask
  task automatic test_async_rst();
    int r;
    do_reset();
    start();
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({bus.IMEM_REQ, bus.BUSY} !== 2'b00) $display("FAIL rst_fetch req/busy: got %b want 00", {bus.IMEM_REQ, bus.BUSY});
    else passed++;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    start();
    fetch(8'h21, 0, r);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({bus.BUSY, bus.EXEC_EN, bus.HALTED} !== 3'b000) $display("FAIL rst_exec busy/en/halt: got %b want 000", {bus.BUSY, bus.EXEC_EN, bus.HALTED});
    else passed++;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    start();
    checks++;
    if (bus.IMEM_REQ !== 1'b1) $display("FAIL rst_restart req: got %b want 1", bus.IMEM_REQ);
    else passed++;
  endtask
  task automatic test_halt_resume();
    do_reset();
    start();
    bus.PC_IN = 5'd7;
    run_instr(8'hC0, "halt");
    checks++;
    if (bus.BUSY !== 1'b0) $display("FAIL halt busy: got %b want 0", bus.BUSY);
    else passed++;
    start();
    checks++;
    if ({bus.IMEM_REQ, bus.PC_STEP, bus.PC_JMP, bus.HALTED} !== 4'b1000)
      $display("FAIL resume req/step/jmp/halt: got %b want 1000", {bus.IMEM_REQ, bus.PC_STEP, bus.PC_JMP, bus.HALTED});
    else passed++;
    run_instr(8'hE3, "reserved");
  endtask
  initial begin
    RST = 1'b1;
    bus.START = 0; bus.IMEM_ACK = 0; bus.IMEM_DATA = '0;
    bus.ZERO_FLAG = 0; bus.EXEC_DONE = 0; bus.PC_IN = '0;
    test_reset();
    test_jz();
    test_call_wrap();
    test_stack_overflow();
    test_exec();
    test_async_rst();
    test_halt_resume();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
